tour_cmd_seq: RTL and testbench

Parametrised tour command sequencer between the tour solver and the command processor. Given a board size, it replays a solved knight's tour. Each one-hot move becomes two commands: a vertical leg, then a horizontal leg with fanfare. It multiplexes its own commands with the UART command stream. It also adds what the fixed 5x5 sequencer lacked: a board-size parameter, an abort-on-UART command, and illegal-move detection.

---
 rtl/tour_pkg.sv | 14 +
 rtl/tour_cmd_seq_move_decode.sv | 20 ++
 rtl/tour_cmd_seq.sv | 74 +++++++
 tb/tb_tour_cmd_seq.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/tour_pkg.sv
// tour_pkg: opcodes, headings, responses and FSM states shared by the tour sequencer
package tour_pkg;
    localparam logic [3:0] OP_MOVE    = 4'h2;
    localparam logic [3:0] OP_FANFARE = 4'h3;
    localparam logic [3:0] OP_ABORT   = 4'hF;
    localparam logic [7:0] HEAD_N     = 8'h00;
    localparam logic [7:0] HEAD_S     = 8'h7F;
    localparam logic [7:0] HEAD_W     = 8'h3F;
    localparam logic [7:0] HEAD_E     = 8'hBF;
    localparam logic [7:0] RESP_ACK   = 8'h5A;
    localparam logic [7:0] RESP_DONE  = 8'hA5;
    localparam logic [7:0] RESP_ABORT = 8'hAB;
    typedef enum logic [2:0] {IDLE, V_ISSUE, V_WAIT, H_ISSUE, H_WAIT} state_t;
endpackage

// File: rtl/tour_cmd_seq_move_decode.sv
// move_decode: turns a one-hot knight move and leg select into a command word
module move_decode
    import tour_pkg::*;
(
    input  logic [7:0]  move,
    input  logic        leg,
    output logic [15:0] cmd,
    output logic        legal
);
    logic north, east, two;
    // moves 0,1,7 go north; moves 0,5,6,7 go east; moves 0,1,4,5 take two vertical squares
    always_comb begin
        north = |(move & 8'h83);
        east  = |(move & 8'hE1);
        two   = |(move & 8'h33);
        legal = $onehot(move);
        cmd   = leg ? {OP_FANFARE, east ? HEAD_E : HEAD_W, two ? 4'd1 : 4'd2}
                    : {OP_MOVE, north ? HEAD_N : HEAD_S, two ? 4'd2 : 4'd1};
    end
endmodule

// File: rtl/tour_cmd_seq.sv
// tour_cmd_seq: replays a solved knight's tour as move/fanfare commands, muxed with UART commands
module tour_cmd_seq
    import tour_pkg::*;
#(
    parameter int BOARD_SIZE = 5,
    parameter int IDX_W      = $clog2(BOARD_SIZE*BOARD_SIZE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_tour,
    input  logic [7:0]       move,
    output logic [IDX_W-1:0] mv_indx,
    input  logic [15:0]      cmd_UART,
    input  logic             cmd_rdy_UART,
    output logic             uart_clr,
    output logic [15:0]      cmd,
    output logic             cmd_rdy,
    input  logic             clr_cmd_rdy,
    input  logic             send_resp,
    output logic [7:0]       resp,
    output logic             tour_busy,
    output logic             tour_err
);
    localparam int NUM_MOVES = BOARD_SIZE*BOARD_SIZE-1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_MOVES-1);
    state_t state, nxt;
    logic abort_pend, legal, last, uart_abort;
    logic [15:0] seq_cmd;
    move_decode u_dec (
        .move  (move),
        .leg   (state == H_ISSUE || state == H_WAIT),
        .cmd   (seq_cmd),
        .legal (legal)
    );
    assign last       = mv_indx == LAST;
    assign uart_abort = state != IDLE && cmd_rdy_UART && cmd_UART[15:12] == OP_ABORT;
    // state, move index and abort flag; index only advances between moves, never past LAST
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mv_indx    <= '0;
            abort_pend <= 1'b0;
        end else begin
            state <= nxt;
            if (state == IDLE && start_tour) begin
                mv_indx    <= '0;
                abort_pend <= 1'b0;
            end else begin
                if (uart_abort) abort_pend <= 1'b1;
                if (state == H_WAIT && send_resp && !last && !abort_pend)
                    mv_indx <= mv_indx + IDX_W'(1);
            end
        end
    end
    // next state and command mux; in IDLE the UART stream passes straight through
    always_comb begin
        nxt       = state;
        tour_busy = state != IDLE;
        uart_clr  = uart_abort;
        tour_err  = state == V_ISSUE && !legal;
        cmd       = state == IDLE ? cmd_UART : seq_cmd;
        cmd_rdy   = state == IDLE ? cmd_rdy_UART : (state == V_ISSUE && legal) || state == H_ISSUE;
        resp      = state == H_WAIT && last ? RESP_DONE :
                    state == H_WAIT && abort_pend ? RESP_ABORT : RESP_ACK;
        case (state)
            IDLE:    nxt = start_tour ? V_ISSUE : IDLE;
            V_ISSUE: nxt = !legal ? IDLE : clr_cmd_rdy ? V_WAIT : V_ISSUE;
            V_WAIT:  nxt = send_resp ? H_ISSUE : V_WAIT;
            H_ISSUE: nxt = clr_cmd_rdy ? H_WAIT : H_ISSUE;
            H_WAIT:  nxt = !send_resp ? H_WAIT : (last || abort_pend) ? IDLE : V_ISSUE;
            default: nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_tour_cmd_seq.sv
// tb_tour_cmd_seq: scoreboard bench for the tour command sequencer (5x5 main instance, 3x3 side instance)
module tb_tour_cmd_seq;
    logic clk = 0, rst = 1;
    logic start_tour = 0, cmd_rdy_UART = 0, clr_cmd_rdy = 0, send_resp = 0;
    logic [7:0] move = 8'h01;
    logic [15:0] cmd_UART = 0;
    logic [4:0] mv_indx;
    logic uart_clr, cmd_rdy, tour_busy, tour_err;
    logic [15:0] cmd;
    logic [7:0] resp;
    logic b3_start = 0, b3_clr = 0, b3_send = 0;
    logic [3:0] b3_mv;
    logic b3_uclr, b3_rdy, b3_busy, b3_err;
    logic [15:0] b3_cmd;
    logic [7:0] b3_resp;
    int errors = 0, checks = 0;
    logic [15:0] cmd_q[$];
    logic [7:0] resp_q[$];

    always #5 clk = ~clk;

    tour_cmd_seq #(.BOARD_SIZE(5)) dut (
        .clk(clk), .rst(rst), .start_tour(start_tour), .move(move), .mv_indx(mv_indx),
        .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART), .uart_clr(uart_clr),
        .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp),
        .resp(resp), .tour_busy(tour_busy), .tour_err(tour_err)
    );

    tour_cmd_seq #(.BOARD_SIZE(3)) dut3 (
        .clk(clk), .rst(rst), .start_tour(b3_start), .move(8'h01), .mv_indx(b3_mv),
        .cmd_UART(16'h0000), .cmd_rdy_UART(1'b0), .uart_clr(b3_uclr),
        .cmd(b3_cmd), .cmd_rdy(b3_rdy), .clr_cmd_rdy(b3_clr), .send_resp(b3_send),
        .resp(b3_resp), .tour_busy(b3_busy), .tour_err(b3_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: every accepted command and every response is popped against the scoreboard
    always @(negedge clk) begin
        if (cmd_rdy && clr_cmd_rdy) begin
            if (cmd_q.size() == 0) check("cmd_unexpected", cmd, 32'hFFFF_FFFF);
            else check("cmd", cmd, cmd_q.pop_front());
        end
        if (send_resp) begin
            if (resp_q.size() == 0) check("resp_unexpected", resp, 32'hFFFF_FFFF);
            else check("resp", resp, resp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start();
        start_tour = 1;
        tick();
        start_tour = 0;
    endtask

    task automatic issue(input logic [15:0] exp);
        int n = 0;
        while (!cmd_rdy && n < 20) begin
            tick();
            n++;
        end
        if (!cmd_rdy) check("cmd_rdy_timeout", 0, 1);
        else begin
            cmd_q.push_back(exp);
            clr_cmd_rdy = 1;
            tick();
            clr_cmd_rdy = 0;
        end
    endtask

    task automatic respond(input logic [7:0] exp);
        resp_q.push_back(exp);
        send_resp = 1;
        tick();
        send_resp = 0;
    endtask

    task automatic do_move(input logic [7:0] mv, input logic [15:0] v, input logic [15:0] h, input logic [7:0] r);
        move = mv;
        issue(v);
        respond(8'h5A);
        issue(h);
        respond(r);
    endtask

    logic [7:0]  ab_mv[4] = '{8'h10, 8'h40, 8'h04, 8'h80};
    logic [15:0] ab_v[4]  = '{16'h27F2, 16'h27F1, 16'h27F1, 16'h2001};
    logic [15:0] ab_h[4]  = '{16'h33F1, 16'h3BF2, 16'h33F2, 16'h3BF2};
    logic [7:0]  il_mv[5] = '{8'h02, 8'h08, 8'h20, 8'h01, 8'h01};
    logic [15:0] il_v[5]  = '{16'h2002, 16'h27F1, 16'h27F2, 16'h2002, 16'h2002};
    logic [15:0] il_h[5]  = '{16'h33F1, 16'h33F2, 16'h3BF1, 16'h3BF1, 16'h3BF1};

    initial begin
        tick();
        tick();
        rst = 0;
        check("rst_busy", tour_busy, 0);
        check("rst_cmd_rdy", cmd_rdy, 0);
        check("rst_uart_clr", uart_clr, 0);
        check("rst_err", tour_err, 0);
        check("rst_mv_indx", mv_indx, 0);
        check("rst_resp", resp, 8'h5A);
        // IDLE passthrough of the UART stream
        cmd_UART = 16'h2345;
        cmd_rdy_UART = 1;
        #1;
        check("idle_cmd", cmd, 16'h2345);
        check("idle_cmd_rdy", cmd_rdy, 1);
        check("idle_resp", resp, 8'h5A);
        cmd_rdy_UART = 0;
        cmd_UART = 0;
        tick();
        // full 5x5 tour with move 0 everywhere
        start();
        check("first_cmd_rdy", cmd_rdy, 1);
        check("busy", tour_busy, 1);
        for (int i = 0; i < 24; i++) begin
            check("tour_mv_indx", mv_indx, i);
            do_move(8'h01, 16'h2002, 16'h3BF1, i == 23 ? 8'hA5 : 8'h5A);
        end
        check("tour_end_busy", tour_busy, 0);
        check("tour_end_mv_indx", mv_indx, 23);
        start_tour = 0;
        tick();
        check("hold_mv_indx", mv_indx, 23);
        // abort captured in V_WAIT of move 3
        start();
        for (int i = 0; i < 3; i++) do_move(ab_mv[i], ab_v[i], ab_h[i], 8'h5A);
        move = ab_mv[3];
        issue(ab_v[3]);
        cmd_UART = 16'hF000;
        cmd_rdy_UART = 1;
        #1;
        check("abort_uart_clr", uart_clr, 1);
        tick();
        cmd_rdy_UART = 0;
        #1;
        check("abort_uart_clr_drop", uart_clr, 0);
        respond(8'h5A);
        issue(ab_h[3]);
        respond(8'hAB);
        check("abort_busy", tour_busy, 0);
        check("abort_mv_indx", mv_indx, 3);
        cmd_UART = 0;
        // illegal move at index 5
        start();
        for (int i = 0; i < 4; i++) do_move(il_mv[i], il_v[i], il_h[i], 8'h5A);
        move = il_mv[4];
        issue(il_v[4]);
        respond(8'h5A);
        issue(il_h[4]);
        move = 8'h03;
        respond(8'h5A);
        check("err_mv_indx", mv_indx, 5);
        check("err_pulse", tour_err, 1);
        check("err_no_cmd_rdy", cmd_rdy, 0);
        tick();
        check("err_pulse_end", tour_err, 0);
        check("err_idle", tour_busy, 0);
        move = 8'h01;
        // reset in H_ISSUE of move 1, then restart
        start();
        do_move(8'h01, 16'h2002, 16'h3BF1, 8'h5A);
        issue(16'h2002);
        respond(8'h5A);
        check("pre_rst_cmd_rdy", cmd_rdy, 1);
        rst = 1;
        tick();
        rst = 0;
        check("mid_rst_busy", tour_busy, 0);
        check("mid_rst_cmd_rdy", cmd_rdy, 0);
        check("mid_rst_mv_indx", mv_indx, 0);
        check("mid_rst_err", tour_err, 0);
        start();
        check("restart_mv_indx", mv_indx, 0);
        do_move(8'h01, 16'h2002, 16'h3BF1, 8'h5A);
        check("restart_next_mv_indx", mv_indx, 1);
        // 3x3 board ends after index 7
        b3_start = 1;
        tick();
        b3_start = 0;
        for (int i = 0; i < 8; i++) begin
            check("b3_mv_indx", b3_mv, i);
            for (int l = 0; l < 2; l++) begin
                int n = 0;
                while (!b3_rdy && n < 20) begin
                    tick();
                    n++;
                end
                check("b3_cmd_rdy", b3_rdy, 1);
                check("b3_cmd", b3_cmd, l == 1 ? 16'h3BF1 : 16'h2002);
                b3_clr = 1;
                tick();
                b3_clr = 0;
                b3_send = 1;
                #1;
                if (l == 1) check("b3_resp", b3_resp, i == 7 ? 8'hA5 : 8'h5A);
                tick();
                b3_send = 0;
            end
        end
        check("b3_end_busy", b3_busy, 0);
        check("b3_end_mv_indx", b3_mv, 7);
        tick();
        check("cmd_q_drained", cmd_q.size(), 0);
        check("resp_q_drained", resp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
